// File: rtl/crc_stream_pkg.sv
// Shared CRC definitions: FSM states, common presets and a bit-reverse helper.
package crc_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, APPEND} state_t;

  typedef struct packed {
    logic [7:0]  wid;
    logic [63:0] poly;
    logic [63:0] init;
    logic        refin;
    logic        refout;
    logic [63:0] xorout;
    logic [63:0] residue;
  } crc_preset_t;

  localparam crc_preset_t CCITT16 = '{
    wid: 8'd16, poly: 64'h1021, init: 64'hffff, refin: 1'b0, refout: 1'b0,
    xorout: 64'h0, residue: 64'h0};

  localparam crc_preset_t CRC32 = '{
    wid: 8'd32, poly: 64'h04c11db7, init: 64'hffffffff, refin: 1'b1, refout: 1'b1,
    xorout: 64'hffffffff, residue: 64'hc704dd7b};

  // Reverses the low w bits of v; bits above w come back zero.
  function automatic logic [63:0] bitrev(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction

endpackage

// File: rtl/crc_stream_step.sv
// Combinational DW-bit LFSR advance of a WID-bit CRC register (MSB feedback).
module crc_step #(
  parameter int             WID   = 16,
  parameter logic [WID-1:0] POLY  = 16'h1021,
  parameter int             DW    = 8,
  parameter bit             REFIN = 1'b0
) (
  input  logic [WID-1:0] sr,
  input  logic [DW-1:0]  data,
  output logic [WID-1:0] sr_next
);

  logic [WID-1:0] s;
  logic           b;
  logic           fb;

  always_comb begin
    s  = sr;
    b  = 1'b0;
    fb = 1'b0;
    for (int i = 0; i < DW; i++) begin
      b  = REFIN ? data[i] : data[DW-1-i];
      fb = s[WID-1] ^ b;
      s  = (s << 1) ^ (fb ? POLY : '0);
    end
    sr_next = s;
  end

endmodule

// File: rtl/crc_stream.sv
// Streaming CRC engine: generate mode appends the CRC after the frame,
// check mode passes the frame through and reports a residue match.
module crc_stream
  import crc_stream_pkg::*;
#(
  parameter int             WID     = 16,
  parameter logic [WID-1:0] POLY    = 16'h1021,
  parameter logic [WID-1:0] INIT    = 16'hffff,
  parameter int             DW      = 8,
  parameter bit             REFIN   = 1'b0,
  parameter bit             REFOUT  = 1'b0,
  parameter logic [WID-1:0] XOROUT  = 16'h0000,
  parameter logic [WID-1:0] RESIDUE = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          res_valid,
  output logic          res_ok
);

  localparam int N  = WID / DW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t         state_q, state_d;
  logic [WID-1:0] sr_q, sr_d, sr_next;
  logic [WID-1:0] crc_q, crc_d, crc_fin;
  logic [63:0]    rev;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           mode_q, mode_d, mode_eff;
  logic           out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [DW-1:0]  out_data_q, out_data_d;
  logic           res_valid_q, res_valid_d, res_ok_q, res_ok_d;
  logic           out_free, in_fire, chunk_last;

  crc_step #(.WID(WID), .POLY(POLY), .DW(DW), .REFIN(REFIN)) u_step (
    .sr      (sr_q),
    .data    (in_data),
    .sr_next (sr_next)
  );

  assign out_free   = ~out_valid_q | out_ready;
  assign in_ready   = ~clear & out_free & (state_q != APPEND);
  assign in_fire    = in_valid & in_ready;
  assign chunk_last = (cnt_q == CW'(N - 1));

  always_comb begin
    rev     = bitrev(64'(sr_next), WID);
    crc_fin = (REFOUT ? rev[WID-1:0] : sr_next) ^ XOROUT;
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    mode_d      = mode_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    res_valid_d = 1'b0;
    res_ok_d    = res_ok_q;
    // mode is only honoured on the opening beat of a frame
    mode_eff    = (state_q == IDLE) ? mode : mode_q;
    if (clear) begin
      state_d     = IDLE;
      sr_d        = INIT;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (in_fire) begin
            mode_d      = mode_eff;
            sr_d        = sr_next;
            state_d     = RUN;
            out_valid_d = 1'b1;
            out_data_d  = in_data;
            out_last_d  = 1'b0;
            if (in_last) begin
              if (mode_eff) begin
                out_last_d  = 1'b1;
                res_valid_d = 1'b1;
                res_ok_d    = (sr_next == RESIDUE);
                sr_d        = INIT;
                state_d     = IDLE;
              end else begin
                crc_d   = crc_fin;
                cnt_d   = '0;
                state_d = APPEND;
              end
            end
          end
        end
        APPEND: begin
          if (out_free) begin
            out_valid_d = 1'b1;
            out_data_d  = REFOUT ? crc_q[DW-1:0] : crc_q[WID-1 -: DW];
            out_last_d  = chunk_last;
            crc_d       = REFOUT ? (crc_q >> DW) : (crc_q << DW);
            cnt_d       = cnt_q + CW'(1);
            if (chunk_last) begin
              sr_d    = INIT;
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      sr_q        <= INIT;
      mode_q      <= 1'b0;
      crc_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_ok_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      mode_q      <= mode_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      res_valid_q <= res_valid_d;
      res_ok_q    <= res_ok_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign res_valid = res_valid_q;
  assign res_ok    = res_ok_q;

endmodule

// File: tb/tb_crc_stream.sv
// Scoreboard bench: CCITT16 instance (d0) and CRC32 instance (d1) share stimulus.
module tb_crc_stream;
  import crc_stream_pkg::*;

  logic       clk = 1'b0;
  logic       rst, clear, mode, in_valid, in_last, out_ready, sel;
  logic [7:0] in_data;
  logic       rdy [2];
  logic       ov  [2];
  logic [7:0] od  [2];
  logic       ol  [2];
  logic       rv  [2];
  logic       rok [2];
  logic       rdy_sel;

  always #5 clk = ~clk;

  assign rdy_sel = sel ? rdy[1] : rdy[0];

  crc_stream #(
    .WID(16), .POLY(CCITT16.poly[15:0]), .INIT(CCITT16.init[15:0]), .DW(8),
    .REFIN(CCITT16.refin), .REFOUT(CCITT16.refout),
    .XOROUT(CCITT16.xorout[15:0]), .RESIDUE(CCITT16.residue[15:0])
  ) u_d0 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_valid(in_valid & ~sel), .in_ready(rdy[0]), .in_data(in_data), .in_last(in_last),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_last(ol[0]),
    .res_valid(rv[0]), .res_ok(rok[0])
  );

  crc_stream #(
    .WID(32), .POLY(CRC32.poly[31:0]), .INIT(CRC32.init[31:0]), .DW(8),
    .REFIN(CRC32.refin), .REFOUT(CRC32.refout),
    .XOROUT(CRC32.xorout[31:0]), .RESIDUE(CRC32.residue[31:0])
  ) u_d1 (
    .clk(clk), .rst(rst), .clear(clear), .mode(mode),
    .in_valid(in_valid & sel), .in_ready(rdy[1]), .in_data(in_data), .in_last(in_last),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_last(ol[1]),
    .res_valid(rv[1]), .res_ok(rok[1])
  );

  int         total = 0;
  int         bad = 0;
  int         stalls = 0;
  bit         bp_en = 1'b0;
  bit         mon_ignore = 1'b0;
  logic [8:0] eq0[$], eq1[$];
  logic       rq0[$], rq1[$];
  logic [7:0] fr[$];
  bit         stall_q [2] = '{1'b0, 1'b0};
  logic [7:0] hold_d [2];
  logic       hold_l [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // out_ready changes well after the active edge so the negedge monitor sees a stable value
  always @(posedge clk) begin
    #2;
    out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic mon(input int d);
    logic [8:0] e;
    logic       r;
    if (stall_q[d]) begin
      total++;
      if (!(ov[d] && od[d] == hold_d[d] && ol[d] == hold_l[d])) begin
        bad++;
        $display("FAIL stable_d%0d: got v=%0b %0h/%0b held %0h/%0b", d, ov[d], od[d], ol[d],
                 hold_d[d], hold_l[d]);
      end
    end
    if (ov[d] && out_ready && !mon_ignore) begin
      if ((d == 0 ? eq0.size() : eq1.size()) == 0) begin
        total++; bad++;
        $display("FAIL stray_out_d%0d: got %0h/%0b expected nothing", d, od[d], ol[d]);
      end else begin
        e = (d == 0) ? eq0.pop_front() : eq1.pop_front();
        chk($sformatf("out_d%0d", d), {ol[d], od[d]}, e);
      end
    end
    if (rv[d] && !mon_ignore) begin
      if ((d == 0 ? rq0.size() : rq1.size()) == 0) begin
        total++; bad++;
        $display("FAIL stray_res_d%0d: got res_ok=%0b expected nothing", d, rok[d]);
      end else begin
        r = (d == 0) ? rq0.pop_front() : rq1.pop_front();
        chk($sformatf("res_ok_d%0d", d), rok[d], r);
      end
    end
    stall_q[d] = ov[d] & ~out_ready;
    hold_d[d]  = od[d];
    hold_l[d]  = ol[d];
  endtask

  always @(negedge clk) if (!rst) begin
    mon(0);
    mon(1);
  end

  task automatic push(input int d, input logic [7:0] b, input logic l);
    if (d == 0) eq0.push_back({l, b}); else eq1.push_back({l, b});
  endtask

  task automatic push_frame(input int d, input logic lastflag);
    foreach (fr[i]) push(d, fr[i], lastflag && (i == fr.size() - 1));
  endtask

  task automatic send(input logic [7:0] b, input logic l);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1; in_data = b; in_last = l;
    #1;
    while (!rdy_sel) begin
      @(negedge clk); #1;
      n++; stalls++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL send_timeout: got no in_ready for %0h expected accept", b);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input int flip_at);
    foreach (fr[i]) begin
      send(fr[i], i == fr.size() - 1);
      if (i == flip_at) mode = ~mode;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 500 && (eq0.size() + eq1.size() + rq0.size() + rq1.size()) != 0; i++)
      @(negedge clk);
    repeat (3) @(negedge clk);
    chk({nm, "_drained"}, eq0.size() + eq1.size() + rq0.size() + rq1.size(), 0);
  endtask

  task automatic load_digits();
    fr.delete();
    for (int i = 1; i <= 9; i++) fr.push_back(8'h30 + 8'(i));
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; mode = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_data = 8'h00; out_ready = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_out_valid_d%0d", d), ov[d], 0);
      chk($sformatf("rst_out_data_d%0d", d), od[d], 0);
      chk($sformatf("rst_out_last_d%0d", d), ol[d], 0);
      chk($sformatf("rst_res_valid_d%0d", d), rv[d], 0);
      chk($sformatf("rst_res_ok_d%0d", d), rok[d], 0);
    end

    // 1: CCITT16 generate, full throughput
    load_digits();
    push_frame(0, 1'b0); push(0, 8'h29, 1'b0); push(0, 8'hb1, 1'b1);
    stalls = 0;
    send_frame(-1);
    idle();
    chk("t1_input_stalls", stalls, 0);
    drain("t1");

    // 2: CCITT16 check, good frame then corrupted frame back to back
    mode = 1'b1;
    load_digits(); fr.push_back(8'h29); fr.push_back(8'hb1);
    push_frame(0, 1'b1); rq0.push_back(1'b1);
    send_frame(-1);
    fr[4] = 8'h34;
    push_frame(0, 1'b1); rq0.push_back(1'b0);
    send_frame(-1);
    idle();
    drain("t2");
    chk("t2_res_ok_held", rok[0], 0);

    // 3: CRC32 generate then check with residue
    sel = 1'b1; mode = 1'b0;
    load_digits();
    push_frame(1, 1'b0);
    push(1, 8'h26, 1'b0); push(1, 8'h39, 1'b0); push(1, 8'hf4, 1'b0); push(1, 8'hcb, 1'b1);
    send_frame(-1);
    idle();
    drain("t3g");
    mode = 1'b1;
    fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hf4); fr.push_back(8'hcb);
    push_frame(1, 1'b1); rq1.push_back(1'b1);
    send_frame(-1);
    idle();
    drain("t3c");
    chk("t3_res_ok_held", rok[1], 1);

    // 4: backpressure, with a mode toggle mid-frame that must be ignored
    sel = 1'b0; mode = 1'b0; bp_en = 1'b1;
    load_digits();
    push_frame(0, 1'b0); push(0, 8'h29, 1'b0); push(0, 8'hb1, 1'b1);
    send_frame(3);
    idle();
    drain("t4");
    bp_en = 1'b0; mode = 1'b0;
    repeat (2) @(negedge clk);

    // 5: back-to-back single-beat frames of 0x00
    fr.delete(); fr.push_back(8'h00);
    for (int k = 0; k < 3; k++) begin
      push(0, 8'h00, 1'b0); push(0, 8'he1, 1'b0); push(0, 8'hf0, 1'b1);
      send_frame(-1);
    end
    idle();
    drain("t5");

    // 6: clear during APPEND, reset during RUN, then a clean frame
    mon_ignore = 1'b1;
    load_digits();
    send_frame(-1);
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("t6_clear_out_valid", ov[0], 0);
    mon_ignore = 1'b0;
    repeat (4) @(negedge clk);
    mon_ignore = 1'b1;
    fr.delete(); fr.push_back(8'h31); fr.push_back(8'h32); fr.push_back(8'h33);
    fr.push_back(8'h34);
    send(fr[0], 1'b0); send(fr[1], 1'b0); send(fr[2], 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    chk("t6_rst_out_valid", ov[0], 0);
    chk("t6_rst_res_valid", rv[0], 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_ignore = 1'b0;
    repeat (3) @(negedge clk);
    load_digits();
    push_frame(0, 1'b0); push(0, 8'h29, 1'b0); push(0, 8'hb1, 1'b1);
    send_frame(-1);
    idle();
    drain("t6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
